// File: rtl/i2c_slave_ctrl.sv
// I2C slave bit/byte sequencer: START/STOP detection, address match,
// byte shifting, ACK generation/checking and delayed open-drain SDA drive.
`timescale 1ns/1ps

module i2c_slave_ctrl #(
  parameter int unsigned SDA_HOLD = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_sync,
  input  logic       sda_sync,
  input  logic       scl_rising,
  input  logic       scl_falling,
  input  logic [6:0] slave_addr,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       sda_out_en,
  output logic       rw_mode,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det,
  output logic       nack_rcvd,
  output logic       tx_underrun
);

  localparam int unsigned HOLD_W = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_BYTE,
    RX_ACK,
    TX_BYTE,
    TX_ACK,
    WAIT_STOP
  } state_t;

  state_t              state_q, state_d;
  logic [BYTE_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
  logic                sda_prev_q;
  logic                ack_phase_q, ack_phase_d;
  logic                ack_ok_q, ack_ok_d;
  logic                pend_q, pend_d;
  logic                pend_val_q, pend_val_d;
  logic [HOLD_W-1:0]   pend_cnt_q, pend_cnt_d;

  logic [BYTE_W-1:0]   rx_data_d;
  logic                rw_mode_d;
  logic                sda_en_d;
  logic                tx_ready_d, rx_valid_d, start_det_d, stop_det_d;
  logic                nack_d, underrun_d, busy_d;

  logic                start_c, stop_c;
  logic [BYTE_W-1:0]   shifted_c;
  logic                sched_c, sched_val_c, tx_load_c;

  assign start_c   = scl_sync & sda_prev_q & ~sda_sync;
  assign stop_c    = scl_sync & ~sda_prev_q & sda_sync;
  assign shifted_c = {shreg_q[BYTE_W-2:0], sda_sync};

  // Next-state, datapath and output decode
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    ack_phase_d = ack_phase_q;
    ack_ok_d    = ack_ok_q;
    pend_d      = pend_q;
    pend_val_d  = pend_val_q;
    pend_cnt_d  = pend_cnt_q;
    rx_data_d   = rx_data;
    rw_mode_d   = rw_mode;
    sda_en_d    = sda_out_en;
    tx_ready_d  = 1'b0;
    rx_valid_d  = 1'b0;
    start_det_d = 1'b0;
    stop_det_d  = 1'b0;
    nack_d      = 1'b0;
    underrun_d  = 1'b0;
    sched_c     = 1'b0;
    sched_val_c = 1'b0;
    tx_load_c   = 1'b0;

    // Drive delay line: apply the scheduled level once the hold count expires
    if (pend_q) begin
      if (pend_cnt_q == '0) begin
        sda_en_d = pend_val_q;
        pend_d   = 1'b0;
      end else begin
        pend_cnt_d = pend_cnt_q - HOLD_W'(1);
      end
    end

    if (start_c) begin
      state_d     = ADDR;
      bitcnt_d    = '0;
      sda_en_d    = 1'b0;
      pend_d      = 1'b0;
      start_det_d = 1'b1;
    end else if (stop_c) begin
      state_d    = IDLE;
      sda_en_d   = 1'b0;
      pend_d     = 1'b0;
      stop_det_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
        end
        ADDR: begin
          if (scl_rising) begin
            shreg_d  = shifted_c;
            bitcnt_d = bitcnt_q + CNT_W'(1);
            if (bitcnt_q == CNT_W'(7)) begin
              if (shifted_c[BYTE_W-1:1] == slave_addr) begin
                rw_mode_d   = shifted_c[0];
                ack_phase_d = 1'b0;
                state_d     = ADDR_ACK;
              end else begin
                state_d = WAIT_STOP;
              end
            end
          end
        end
        ADDR_ACK, RX_ACK: begin
          // First falling edge starts the ACK drive, second one ends the ACK clock
          if (scl_falling) begin
            if (!ack_phase_q) begin
              sched_c     = 1'b1;
              sched_val_c = 1'b1;
              ack_phase_d = 1'b1;
            end else begin
              bitcnt_d = '0;
              if ((state_q == ADDR_ACK) && rw_mode) begin
                tx_load_c = 1'b1;
                state_d   = TX_BYTE;
              end else begin
                sched_c     = 1'b1;
                sched_val_c = 1'b0;
                state_d     = RX_BYTE;
              end
            end
          end
        end
        RX_BYTE: begin
          if (scl_rising) begin
            shreg_d  = shifted_c;
            bitcnt_d = bitcnt_q + CNT_W'(1);
            if (bitcnt_q == CNT_W'(7)) begin
              rx_data_d   = shifted_c;
              rx_valid_d  = 1'b1;
              ack_phase_d = 1'b0;
              state_d     = RX_ACK;
            end
          end
        end
        TX_BYTE: begin
          if (scl_falling) begin
            sched_c = 1'b1;
            if (bitcnt_q == CNT_W'(7)) begin
              sched_val_c = 1'b0;
              ack_ok_d    = 1'b0;
              state_d     = TX_ACK;
            end else begin
              shreg_d     = {shreg_q[BYTE_W-2:0], 1'b0};
              sched_val_c = ~shreg_q[BYTE_W-2];
              bitcnt_d    = bitcnt_q + CNT_W'(1);
            end
          end
        end
        TX_ACK: begin
          if (scl_rising) begin
            if (!sda_sync) begin
              ack_ok_d = 1'b1;
            end else begin
              nack_d  = 1'b1;
              state_d = WAIT_STOP;
            end
          end else if (scl_falling && ack_ok_q) begin
            tx_load_c = 1'b1;
            ack_ok_d  = 1'b0;
            bitcnt_d  = '0;
            state_d   = TX_BYTE;
          end
        end
        WAIT_STOP: begin
          sda_en_d = 1'b0;
          pend_d   = 1'b0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      // Byte load for transmission; the first bit's drive is scheduled here
      if (tx_load_c) begin
        tx_ready_d = 1'b1;
        if (tx_valid) begin
          shreg_d = tx_data;
        end else begin
          shreg_d    = '1;
          underrun_d = 1'b1;
        end
        sched_c     = 1'b1;
        sched_val_c = ~shreg_d[BYTE_W-1];
      end

      if (sched_c) begin
        pend_d     = 1'b1;
        pend_val_d = sched_val_c;
        pend_cnt_d = HOLD_W'(SDA_HOLD);
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      sda_prev_q  <= 1'b1;
      ack_phase_q <= 1'b0;
      ack_ok_q    <= 1'b0;
      pend_q      <= 1'b0;
      pend_val_q  <= 1'b0;
      pend_cnt_q  <= '0;
      rx_data     <= '0;
      rw_mode     <= 1'b0;
      sda_out_en  <= 1'b0;
      tx_ready    <= 1'b0;
      rx_valid    <= 1'b0;
      start_det   <= 1'b0;
      stop_det    <= 1'b0;
      nack_rcvd   <= 1'b0;
      tx_underrun <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      sda_prev_q  <= sda_sync;
      ack_phase_q <= ack_phase_d;
      ack_ok_q    <= ack_ok_d;
      pend_q      <= pend_d;
      pend_val_q  <= pend_val_d;
      pend_cnt_q  <= pend_cnt_d;
      rx_data     <= rx_data_d;
      rw_mode     <= rw_mode_d;
      sda_out_en  <= sda_en_d;
      tx_ready    <= tx_ready_d;
      rx_valid    <= rx_valid_d;
      start_det   <= start_det_d;
      stop_det    <= stop_det_d;
      nack_rcvd   <= nack_d;
      tx_underrun <= underrun_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Scoreboard bench for i2c_slave_ctrl: the bench plays the I2C master and
// the byte-side logic, and checks drive timing, bytes and event pulses.
`timescale 1ns/1ps

module tb_i2c_slave_ctrl;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_sync, sda_sync, scl_rising, scl_falling;
  logic [6:0] slave_addr;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, sda_out_en, rw_mode, busy;
  logic       start_det, stop_det, nack_rcvd, tx_underrun;

  int n_checks = 0;
  int n_pass   = 0;
  int n_start = 0, n_stop = 0, n_nack = 0, n_under = 0, n_rxv = 0, n_txr = 0;

  logic [7:0] rx_q[$];
  logic       tx_q[$];

  i2c_slave_ctrl #(.SDA_HOLD(2)) dut (
    .clk(clk), .rst(rst),
    .scl_sync(scl_sync), .sda_sync(sda_sync),
    .scl_rising(scl_rising), .scl_falling(scl_falling),
    .slave_addr(slave_addr),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .sda_out_en(sda_out_en), .rw_mode(rw_mode), .busy(busy),
    .start_det(start_det), .stop_det(stop_det),
    .nack_rcvd(nack_rcvd), .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // Byte-side monitor: pops scoreboard entries as the DUT produces them
  always @(negedge clk) begin
    if (!rst) begin
      if (start_det) n_start++;
      if (stop_det) n_stop++;
      if (nack_rcvd) n_nack++;
      if (tx_underrun) n_under++;
      if (rx_valid) begin
        n_rxv++;
        if (rx_q.size() == 0) chk("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
        else begin
          logic [7:0] e;
          e = rx_q.pop_front();
          chk("rx_data", 32'(rx_data), 32'(e));
        end
      end
      if (tx_ready) begin
        n_txr++;
        if (tx_q.size() == 0) chk("tx_unexpected", 32'(tx_underrun), 32'hFFFF_FFFF);
        else begin
          logic e;
          e = tx_q.pop_front();
          chk("tx_underrun_flag", 32'(tx_underrun), 32'(e));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_up();
    @(negedge clk); scl_sync = 1'b1; scl_rising = 1'b1;
    @(negedge clk); scl_rising = 1'b0;
  endtask

  task automatic scl_dn();
    @(negedge clk); scl_sync = 1'b0; scl_falling = 1'b1;
    @(negedge clk); scl_falling = 1'b0;
  endtask

  // One SCL clock; slave drive is checked while SCL is high
  task automatic bit_clk(input logic msda, input logic exp_en, input string tag);
    @(negedge clk); sda_sync = msda;
    wait_cyc(HALF);
    scl_up();
    wait_cyc(HALF);
    chk(tag, 32'(sda_out_en), 32'(exp_en));
    scl_dn();
  endtask

  task automatic master_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bit_clk(b[i], 1'b0, "wr_bit_drive");
  endtask

  task automatic slave_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bit_clk(1'b1, ~b[i], "rd_bit_drive");
  endtask

  task automatic start_cond();
    if (!scl_sync) begin
      @(negedge clk); sda_sync = 1'b1;
      wait_cyc(HALF);
      scl_up();
      wait_cyc(HALF);
    end
    @(negedge clk); sda_sync = 1'b0;
    wait_cyc(HALF);
    scl_dn();
  endtask

  task automatic stop_cond();
    @(negedge clk); sda_sync = 1'b0;
    wait_cyc(HALF);
    scl_up();
    wait_cyc(HALF);
    @(negedge clk); sda_sync = 1'b1;
    wait_cyc(HALF);
  endtask

  initial begin
    int s0, p0, r0, t0, k0, u0;
    rst = 1'b1; scl_sync = 1'b1; sda_sync = 1'b1;
    scl_rising = 1'b0; scl_falling = 1'b0;
    slave_addr = 7'h42; tx_data = 8'h00; tx_valid = 1'b0;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2);
    chk("reset_sda_en", 32'(sda_out_en), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_rx_data", 32'(rx_data), 0);
    chk("reset_rw_mode", 32'(rw_mode), 0);

    // Write 0xA5 to own address, with ACK drive timing check
    s0 = n_start; p0 = n_stop; r0 = n_rxv;
    rx_q.push_back(8'hA5);
    start_cond();
    chk("wr_busy", 32'(busy), 1);
    master_byte(8'h84);
    chk("ack_hold_t0", 32'(sda_out_en), 0);
    wait_cyc(1); chk("ack_hold_t1", 32'(sda_out_en), 0);
    wait_cyc(1); chk("ack_hold_t2", 32'(sda_out_en), 0);
    wait_cyc(1); chk("ack_hold_t3", 32'(sda_out_en), 1);
    bit_clk(1'b1, 1'b1, "addr_ack");
    master_byte(8'hA5);
    bit_clk(1'b1, 1'b1, "data_ack");
    stop_cond();
    chk("wr_start_cnt", 32'(n_start - s0), 1);
    chk("wr_stop_cnt", 32'(n_stop - p0), 1);
    chk("wr_rxv_cnt", 32'(n_rxv - r0), 1);
    chk("wr_rw_mode", 32'(rw_mode), 0);
    chk("wr_rx_hold", 32'(rx_data), 32'hA5);
    chk("wr_busy_end", 32'(busy), 0);
    chk("wr_sda_end", 32'(sda_out_en), 0);

    // Address mismatch: never drives, no byte delivered
    r0 = n_rxv;
    start_cond();
    master_byte(8'h86);
    bit_clk(1'b1, 1'b0, "mis_no_ack");
    master_byte(8'hA5);
    bit_clk(1'b1, 1'b0, "mis_no_ack2");
    chk("mis_busy", 32'(busy), 1);
    stop_cond();
    chk("mis_busy_end", 32'(busy), 0);
    chk("mis_rxv_cnt", 32'(n_rxv - r0), 0);

    // Read two bytes: ACK then NACK
    t0 = n_txr; k0 = n_nack; u0 = n_under;
    tx_valid = 1'b1; tx_data = 8'h3C;
    tx_q.push_back(1'b0); tx_q.push_back(1'b0);
    start_cond();
    master_byte(8'h85);
    bit_clk(1'b1, 1'b1, "rd_addr_ack");
    chk("rd_rw_mode", 32'(rw_mode), 1);
    slave_byte(8'h3C);
    tx_data = 8'hF0;
    bit_clk(1'b0, 1'b0, "rd_m_ack");
    slave_byte(8'hF0);
    bit_clk(1'b1, 1'b0, "rd_m_nack");
    stop_cond();
    chk("rd_txr_cnt", 32'(n_txr - t0), 2);
    chk("rd_nack_cnt", 32'(n_nack - k0), 1);
    chk("rd_under_cnt", 32'(n_under - u0), 0);
    chk("rd_sda_end", 32'(sda_out_en), 0);

    // Underrun: byte goes out as 0xFF
    u0 = n_under; k0 = n_nack;
    tx_valid = 1'b0;
    tx_q.push_back(1'b1);
    start_cond();
    master_byte(8'h85);
    bit_clk(1'b1, 1'b1, "ur_addr_ack");
    slave_byte(8'hFF);
    bit_clk(1'b1, 1'b0, "ur_m_nack");
    stop_cond();
    chk("ur_under_cnt", 32'(n_under - u0), 1);
    chk("ur_nack_cnt", 32'(n_nack - k0), 1);

    // Repeated START after 4 data bits
    s0 = n_start; r0 = n_rxv;
    start_cond();
    master_byte(8'h84);
    bit_clk(1'b1, 1'b1, "rs_addr_ack");
    bit_clk(1'b1, 1'b0, "rs_part0");
    bit_clk(1'b0, 1'b0, "rs_part1");
    bit_clk(1'b1, 1'b0, "rs_part2");
    bit_clk(1'b0, 1'b0, "rs_part3");
    start_cond();
    chk("rs_start_cnt", 32'(n_start - s0), 2);
    chk("rs_no_partial", 32'(n_rxv - r0), 0);
    master_byte(8'h84);
    bit_clk(1'b1, 1'b1, "rs_readdr_ack");
    rx_q.push_back(8'h5A);
    master_byte(8'h5A);
    bit_clk(1'b1, 1'b1, "rs_data_ack");
    stop_cond();
    chk("rs_rxv_cnt", 32'(n_rxv - r0), 1);

    // Reset while ACK is being driven
    s0 = n_start; r0 = n_rxv;
    start_cond();
    master_byte(8'h84);
    wait_cyc(4);
    chk("rst_pre_drive", 32'(sda_out_en), 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_sda_en", 32'(sda_out_en), 0);
    chk("rst_busy", 32'(busy), 0);
    scl_up();
    wait_cyc(HALF);
    scl_dn();
    master_byte(8'h84);
    bit_clk(1'b1, 1'b0, "rst_ignored_ack");
    chk("rst_busy_after", 32'(busy), 0);
    chk("rst_rxv_cnt", 32'(n_rxv - r0), 0);
    chk("rst_start_cnt", 32'(n_start - s0), 1);

    wait_cyc(4);
    chk("rx_q_empty", 32'(rx_q.size()), 0);
    chk("tx_q_empty", 32'(tx_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
